// File: rtl/poker_key_input.sv
// poker_key_input
//   Turns USB HID keycodes (already synchronous to clk) into poker actions
//   for the hand-state FSM. It also keeps an on-screen bet entry of up to
//   MAX_DIGITS BCD digits.
//
//   Build option: define POKER_KEY_REPEAT_EN to make a held Backspace
//   auto-repeat. The first repeat comes after REPEAT_DELAY cycles and the
//   rest follow every REPEAT_RATE cycles. Without the macro no repeat
//   counter is built.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   keycode[31:0]          four HID keycodes; only [7:0] is decoded
//   enable                 high while the FSM waits for this player's action
//   to_call, player_stack  sampled only at the commit key press
//   action_valid/ready     offer handshake; type/amount stay stable while offered
//   action_type            0 FOLD, 1 CHECK_CALL, 2 BET_RAISE, 3 ALL_IN
//   action_amount          chips committed by the offered action
//   entry_amount           binary value of the BCD entry (saturated)
//   entry_digits           number of digits entered
//   entry_error            one-cycle pulse when a commit is rejected
module poker_key_input #(
  parameter int MAX_STACK_W  = 11,
  parameter int MAX_DIGITS   = 4,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            keycode,
  input  logic                   enable,
  input  logic [MAX_STACK_W-1:0] to_call,
  input  logic [MAX_STACK_W-1:0] player_stack,
  output logic                   action_valid,
  input  logic                   action_ready,
  output logic [1:0]             action_type,
  output logic [MAX_STACK_W-1:0] action_amount,
  output logic [MAX_STACK_W-1:0] entry_amount,
  output logic [2:0]             entry_digits,
  output logic                   entry_error
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [1:0] ACT_FOLD  = 2'd0;
  localparam logic [1:0] ACT_CALL  = 2'd1;
  localparam logic [1:0] ACT_BET   = 2'd2;
  localparam logic [1:0] ACT_ALLIN = 2'd3;

  localparam logic [7:0] KC_A      = 8'h04;
  localparam logic [7:0] KC_B      = 8'h05;
  localparam logic [7:0] KC_C      = 8'h06;
  localparam logic [7:0] KC_F      = 8'h09;
  localparam logic [7:0] KC_DIG1   = 8'h1E;
  localparam logic [7:0] KC_DIG0   = 8'h27;
  localparam logic [7:0] KC_ENTER  = 8'h28;
  localparam logic [7:0] KC_ESC    = 8'h29;
  localparam logic [7:0] KC_BSPACE = 8'h2A;

  localparam logic [31:0] ENTRY_MAX  = 32'((64'd1 << MAX_STACK_W) - 64'd1);
  localparam logic [2:0]  DIGITS_CAP = 3'(MAX_DIGITS);

  state_t                 state_reg, state_next;
  logic [7:0]             kc;
  logic [7:0]             prev_kc_reg;
  logic                   enable_prev_reg;
  logic                   enable_rise;
  logic [3:0]             bcd_reg  [MAX_DIGITS];
  logic [3:0]             bcd_next [MAX_DIGITS];
  logic [2:0]             digits_reg, digits_next;
  logic [1:0]             type_reg, type_next;
  logic [MAX_STACK_W-1:0] amount_reg, amount_next;
  logic                   error_reg, error_next;
  logic                   key_event;
  logic                   rpt_fire;
  logic                   is_digit;
  logic [7:0]             kc_off;
  logic [3:0]             digit_val;
  logic [31:0]            entry_raw;
  logic                   unused_hi_keycode;

  assign kc                = keycode[7:0];
  assign unused_hi_keycode = ^keycode[31:8];
  assign enable_rise       = enable && !enable_prev_reg;

  // A key produces an event only on the cycle its code first appears, so a
  // held key produces exactly one event. An auto-repeat adds extra events.
  assign key_event = ((kc != 8'h00) && (kc != prev_kc_reg)) || rpt_fire;

  // Digit decode: 0x1E..0x26 are 1..9, and 0x27 is 0.
  assign is_digit  = (kc >= KC_DIG1) && (kc <= KC_DIG0);
  assign kc_off    = kc - 8'h1D;
  assign digit_val = (kc == KC_DIG0) ? 4'd0 : kc_off[3:0];

  // BCD to binary. The most significant digit is folded in first. The result
  // saturates at the largest chip amount.
  always_comb begin
    entry_raw = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      entry_raw = entry_raw * 32'd10 + 32'(bcd_reg[i]);
    end
    if (entry_raw > ENTRY_MAX) entry_amount = '1;
    else                       entry_amount = entry_raw[MAX_STACK_W-1:0];
  end

`ifdef POKER_KEY_REPEAT_EN
  // rpt_cnt_reg counts the cycles since the last Backspace event, whether that
  // event was real or a repeat. rpt_phase_reg selects the delay or rate period.
  logic [31:0] rpt_cnt_reg;
  logic        rpt_phase_reg;
  logic        bs_held;

  assign bs_held  = (kc == KC_BSPACE) && (prev_kc_reg == KC_BSPACE);
  assign rpt_fire = bs_held && (rpt_phase_reg ? (rpt_cnt_reg == 32'(REPEAT_RATE))
                                              : (rpt_cnt_reg == 32'(REPEAT_DELAY)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_reg   <= '0;
      rpt_phase_reg <= 1'b0;
    end else if (kc != prev_kc_reg) begin
      rpt_cnt_reg   <= 32'd1;
      rpt_phase_reg <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt_reg   <= 32'd1;
      rpt_phase_reg <= 1'b1;
    end else if (bs_held) begin
      rpt_cnt_reg   <= rpt_cnt_reg + 32'd1;
    end
  end
`else
  logic unused_repeat_cfg;
  assign rpt_fire          = 1'b0;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic and datapath
  always_comb begin
    state_next  = state_reg;
    bcd_next    = bcd_reg;
    digits_next = digits_reg;
    type_next   = type_reg;
    amount_next = amount_reg;
    error_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable_rise) begin
          // A new turn starts with an empty entry. A key that lands on the
          // same cycle as the rise is dropped, not applied.
          for (int i = 0; i < MAX_DIGITS; i++) bcd_next[i] = 4'd0;
          digits_next = '0;
        end else if (enable && key_event) begin
          if (is_digit) begin
            if ((digits_reg < DIGITS_CAP) && !((digit_val == 4'd0) && (digits_reg == 3'd0))) begin
              for (int i = MAX_DIGITS - 1; i > 0; i--) bcd_next[i] = bcd_reg[i-1];
              bcd_next[0] = digit_val;
              digits_next = digits_reg + 3'd1;
            end
          end else begin
            case (kc)
              KC_BSPACE: begin
                if (digits_reg != 3'd0) begin
                  for (int i = 0; i < MAX_DIGITS - 1; i++) bcd_next[i] = bcd_reg[i+1];
                  bcd_next[MAX_DIGITS-1] = 4'd0;
                  digits_next = digits_reg - 3'd1;
                end
              end
              KC_ESC: begin
                for (int i = 0; i < MAX_DIGITS; i++) bcd_next[i] = 4'd0;
                digits_next = '0;
              end
              KC_F: begin
                state_next  = PEND;
                type_next   = ACT_FOLD;
                amount_next = '0;
              end
              KC_C: begin
                state_next  = PEND;
                type_next   = ACT_CALL;
                amount_next = (to_call < player_stack) ? to_call : player_stack;
              end
              KC_A: begin
                if (player_stack != '0) begin
                  state_next  = PEND;
                  type_next   = ACT_ALLIN;
                  amount_next = player_stack;
                end else begin
                  error_next  = 1'b1;
                end
              end
              KC_B, KC_ENTER: begin
                if ((entry_amount > to_call) && (entry_amount <= player_stack)) begin
                  state_next  = PEND;
                  type_next   = ACT_BET;
                  amount_next = entry_amount;
                end else begin
                  error_next  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      PEND: begin
        // The offer stays up even if enable drops. It ends only on a transfer.
        if (action_ready || enable_rise) begin
          for (int i = 0; i < MAX_DIGITS; i++) bcd_next[i] = 4'd0;
          digits_next = '0;
        end
        if (action_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_kc_reg     <= '0;
      enable_prev_reg <= 1'b0;
      digits_reg      <= '0;
      type_reg        <= ACT_FOLD;
      amount_reg      <= '0;
      error_reg       <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) bcd_reg[i] <= 4'd0;
    end else begin
      prev_kc_reg     <= kc;
      enable_prev_reg <= enable;
      digits_reg      <= digits_next;
      type_reg        <= type_next;
      amount_reg      <= amount_next;
      error_reg       <= error_next;
      bcd_reg         <= bcd_next;
    end
  end

  // action_valid comes from the state register, so an asynchronous reset
  // removes the offer at once.
  assign action_valid  = (state_reg == PEND);
  assign action_type   = type_reg;
  assign action_amount = amount_reg;
  assign entry_digits  = digits_reg;
  assign entry_error   = error_reg;

endmodule

// File: tb/tb_poker_key_input.sv
// Testbench for poker_key_input in its default build (no key repeat).
// Inputs are driven at the falling edge and outputs are sampled there too.
// The bet entry is modelled as a plain integer value with a digit count.
module tb_poker_key_input;
  localparam int W    = 11;
  localparam int MAXV = 2047;

  localparam logic [7:0] K_A = 8'h04, K_B = 8'h05, K_C = 8'h06, K_F = 8'h09;
  localparam logic [7:0] K_ENTER = 8'h28, K_ESC = 8'h29, K_BS = 8'h2A;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  keycode;
  logic         enable;
  logic [W-1:0] to_call, player_stack;
  logic         action_valid, action_ready;
  logic [1:0]   action_type;
  logic [W-1:0] action_amount, entry_amount;
  logic [2:0]   entry_digits;
  logic         entry_error;

  int errors = 0;
  int checks = 0;
  int m_val  = 0;   // reference entry value
  int m_dig  = 0;   // reference digit count

  always #5 clk = ~clk;

  poker_key_input dut (
    .clk(clk), .reset_n(reset_n), .keycode(keycode), .enable(enable),
    .to_call(to_call), .player_stack(player_stack),
    .action_valid(action_valid), .action_ready(action_ready),
    .action_type(action_type), .action_amount(action_amount),
    .entry_amount(entry_amount), .entry_digits(entry_digits),
    .entry_error(entry_error)
  );

  function automatic logic [7:0] key_of(input int d);
    logic [7:0] k;
    k = (d == 0) ? 8'h27 : 8'(8'h1D + d);
    return k;
  endfunction

  function automatic int exp_entry();
    return (m_val > MAXV) ? MAXV : m_val;
  endfunction

  // Reference rules for the keys that edit the entry
  task automatic model_entry(input logic [7:0] k);
    int d;
    if (k >= 8'h1E && k <= 8'h27) begin
      d = (k == 8'h27) ? 0 : int'(k) - 'h1D;
      if (m_dig < 4 && !(d == 0 && m_dig == 0)) begin
        m_val = m_val * 10 + d;
        m_dig++;
      end
    end else if (k == K_BS) begin
      if (m_dig > 0) begin
        m_val = m_val / 10;
        m_dig--;
      end
    end else if (k == K_ESC) begin
      m_val = 0;
      m_dig = 0;
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = {24'h0, k};
    @(negedge clk);
  endtask

  task automatic release_key();
    keycode = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; keycode = '0; action_ready = 1'b0;
    to_call = '0; player_stack = '0;
    repeat (3) @(negedge clk);
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", action_valid); end
    checks++; if (action_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", action_type); end
    checks++; if (action_amount !== '0) begin errors++; $display("FAIL reset_amount: got %0d expected 0", action_amount); end
    checks++; if (entry_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", entry_error); end
    checks++; if (entry_digits !== 3'd0) begin errors++; $display("FAIL reset_digits: got %0d expected 0", entry_digits); end
    checks++; if (entry_amount !== '0) begin errors++; $display("FAIL reset_entry: got %0d expected 0", entry_amount); end
    reset_n = 1'b1;
    @(negedge clk);
    m_val = 0; m_dig = 0;
    $display("reset: valid=%0b digits=%0d", action_valid, entry_digits);
  endtask

  task automatic test_digit_entry();
    int ds[4] = '{1, 2, 5, 0};
    to_call = 11'd100; player_stack = 11'd999;
    foreach (ds[i]) begin
      press(key_of(ds[i]));
      model_entry(key_of(ds[i]));
      checks++; if (entry_digits !== 3'(m_dig)) begin errors++; $display("FAIL digit_count: got %0d expected %0d", entry_digits, m_dig); end
      release_key();
    end
    checks++; if (entry_amount !== 11'd1250) begin errors++; $display("FAIL digit_value: got %0d expected 1250", entry_amount); end
    press(K_ENTER);
    checks++; if (entry_error !== 1'b1) begin errors++; $display("FAIL reject_pulse: got %0b expected 1", entry_error); end
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL reject_valid: got %0b expected 0", action_valid); end
    release_key();
    checks++; if (entry_error !== 1'b0) begin errors++; $display("FAIL reject_pulse_len: got %0b expected 0", entry_error); end
    checks++; if (entry_digits !== 3'd4) begin errors++; $display("FAIL reject_keeps_entry: got %0d expected 4", entry_digits); end
    press(K_ESC); model_entry(K_ESC); release_key();
    checks++; if (entry_digits !== 3'd0) begin errors++; $display("FAIL escape_clear: got %0d expected 0", entry_digits); end
    $display("digit_entry: entry=1250 rejected, error pulse seen");
  endtask

  task automatic test_bet();
    to_call = 11'd100; player_stack = 11'd1000; action_ready = 1'b0;
    press(key_of(3)); release_key();
    press(key_of(0)); release_key();
    press(key_of(0)); release_key();
    checks++; if (entry_amount !== 11'd300) begin errors++; $display("FAIL bet_entry: got %0d expected 300", entry_amount); end
    press(K_B);
    keycode = '0;
    // Inputs seen after the commit must not change the offer.
    to_call = 11'd2000; player_stack = 11'd5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (action_valid !== 1'b1 || action_type !== 2'd2 || action_amount !== 11'd300) begin
        errors++;
        $display("FAIL bet_hold: cycle %0d got valid=%0b type=%0d amt=%0d expected 1/2/300", i, action_valid, action_type, action_amount);
      end
      @(negedge clk);
    end
    action_ready = 1'b1;
    @(negedge clk);
    action_ready = 1'b0;
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL bet_drop: got %0b expected 0", action_valid); end
    checks++; if (entry_amount !== '0 || entry_digits !== 3'd0) begin errors++; $display("FAIL bet_clear: got entry=%0d digits=%0d expected 0/0", entry_amount, entry_digits); end
    m_val = 0; m_dig = 0;
    $display("bet: type=2 amount=300 held 5 cycles then transferred");
  endtask

  task automatic test_call_clip();
    to_call = 11'd500; player_stack = 11'd120; action_ready = 1'b1;
    press(K_C);
    keycode = '0;
    checks++; if (action_valid !== 1'b1 || action_type !== 2'd1 || action_amount !== 11'd120) begin
      errors++; $display("FAIL call_clip: got valid=%0b type=%0d amt=%0d expected 1/1/120", action_valid, action_type, action_amount); end
    @(negedge clk);
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL call_one_cycle: got %0b expected 0", action_valid); end
    action_ready = 1'b0;
    $display("call_clip: amount clipped to stack 120");
  endtask

  task automatic test_held_fold();
    int seen = 0;
    action_ready = 1'b1;
    keycode = {24'h0, K_F};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (action_valid === 1'b1) begin
        seen++;
        checks++; if (action_type !== 2'd0 || action_amount !== '0) begin errors++; $display("FAIL fold_value: got type=%0d amt=%0d expected 0/0", action_type, action_amount); end
      end
    end
    keycode = '0;
    @(negedge clk);
    action_ready = 1'b0;
    checks++; if (seen !== 1) begin errors++; $display("FAIL held_fold_count: got %0d expected 1", seen); end
    $display("held_fold: %0d fold offers over 100 held cycles", seen);
  endtask

  task automatic test_gating();
    enable = 1'b0;
    press(key_of(7)); release_key();
    checks++; if (entry_digits !== 3'd0) begin errors++; $display("FAIL gated_digit: got %0d expected 0", entry_digits); end
    enable = 1'b1;
    @(negedge clk);
    $display("gating: digit with enable=0 ignored");
  endtask

  task automatic test_backspace();
    logic [7:0] seq[5] = '{8'h21, 8'h22, 8'h2A, 8'h2A, 8'h2A};
    int want_amt[5] = '{4, 45, 4, 0, 0};
    foreach (seq[i]) begin
      press(seq[i]); model_entry(seq[i]); release_key();
      checks++; if (entry_amount !== 11'(want_amt[i]) || entry_digits !== 3'(m_dig)) begin
        errors++; $display("FAIL backspace_step%0d: got %0d/%0d expected %0d/%0d", i, entry_amount, entry_digits, want_amt[i], m_dig); end
    end
    press(key_of(0)); model_entry(key_of(0)); release_key();
    checks++; if (entry_digits !== 3'd0) begin errors++; $display("FAIL leading_zero: got %0d expected 0", entry_digits); end
    for (int d = 1; d <= 5; d++) begin
      press(key_of(d)); model_entry(key_of(d)); release_key();
    end
    checks++; if (entry_digits !== 3'd4 || entry_amount !== 11'd1234) begin
      errors++; $display("FAIL fifth_digit: got %0d/%0d expected 4/1234", entry_digits, entry_amount); end
    press(K_ESC); model_entry(K_ESC); release_key();
    $display("backspace: 45 -> 4 -> 0 -> 0, leading zero and fifth digit ignored");
  endtask

  task automatic test_reset_mid_pend();
    action_ready = 1'b0;
    press(key_of(9)); release_key();
    press(key_of(8)); release_key();
    press(K_F); release_key();
    checks++; if (action_valid !== 1'b1) begin errors++; $display("FAIL pend_offer: got %0b expected 1", action_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL async_drop: got %0b expected 0", action_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    m_val = 0; m_dig = 0;
    @(negedge clk);
    checks++; if (entry_digits !== 3'd0 || entry_amount !== '0 || action_valid !== 1'b0) begin
      errors++; $display("FAIL after_reset: got digits=%0d entry=%0d valid=%0b expected 0/0/0", entry_digits, entry_amount, action_valid); end
    press(key_of(2)); model_entry(key_of(2)); release_key();
    checks++; if (entry_digits !== 3'd1) begin errors++; $display("FAIL idle_after_reset: got %0d expected 1", entry_digits); end
    press(K_ESC); model_entry(K_ESC); release_key();
    $display("reset_mid_pend: offer dropped asynchronously, entry empty");
  endtask

  task automatic test_random();
    logic [7:0] keys[17] = '{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                             8'h27, 8'h2A, 8'h29, 8'h09, 8'h06, 8'h04, 8'h05, 8'h28};
    logic [7:0] k;
    logic [31:0] r;
    int tc, st, e, exp_type, exp_amt, waitn;
    bit exp_commit, exp_err;
    for (int n = 0; n < 300; n++) begin
      k  = keys[$urandom_range(0, 16)];
      tc = $urandom_range(0, 400);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV);
      to_call = 11'(tc); player_stack = 11'(st);
      exp_commit = 0; exp_err = 0; exp_type = 0; exp_amt = 0;
      e = exp_entry();
      case (k)
        K_F:     begin exp_commit = 1; exp_type = 0; exp_amt = 0; end
        K_C:     begin exp_commit = 1; exp_type = 1; exp_amt = (tc < st) ? tc : st; end
        K_A:     if (st != 0) begin exp_commit = 1; exp_type = 3; exp_amt = st; end else exp_err = 1;
        K_B, K_ENTER: if (e > tc && e <= st) begin exp_commit = 1; exp_type = 2; exp_amt = e; end else exp_err = 1;
        default: ;
      endcase
      r = $urandom();
      keycode = {r[23:0], k};
      @(negedge clk);
      checks++;
      if (action_valid !== exp_commit || entry_error !== exp_err ||
          (exp_commit && (action_type !== 2'(exp_type) || action_amount !== 11'(exp_amt)))) begin
        errors++;
        $display("FAIL rand%0d key=%02h: got v=%0b err=%0b t=%0d a=%0d expected v=%0b err=%0b t=%0d a=%0d",
                 n, k, action_valid, entry_error, action_type, action_amount, exp_commit, exp_err, exp_type, exp_amt);
      end
      r = $urandom();
      keycode = {r[23:0], 8'h00};
      if (exp_commit) begin
        waitn = $urandom_range(0, 3);
        for (int w = 0; w < waitn; w++) begin
          @(negedge clk);
          checks++; if (action_valid !== 1'b1) begin errors++; $display("FAIL rand%0d hold: got %0b expected 1", n, action_valid); end
        end
        action_ready = 1'b1;
        @(negedge clk);
        action_ready = 1'b0;
        m_val = 0; m_dig = 0;
        checks++; if (action_valid !== 1'b0 || entry_digits !== 3'd0) begin
          errors++; $display("FAIL rand%0d transfer: got v=%0b digits=%0d expected 0/0", n, action_valid, entry_digits); end
      end else begin
        model_entry(k);
        @(negedge clk);
        checks++; if (entry_digits !== 3'(m_dig) || entry_amount !== 11'(exp_entry())) begin
          errors++; $display("FAIL rand%0d entry: got %0d/%0d expected %0d/%0d", n, entry_digits, entry_amount, m_dig, exp_entry()); end
      end
    end
    $display("random: 300 key presses compared with the model");
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_bet();
    test_call_clip();
    test_held_fold();
    test_gating();
    test_backspace();
    test_reset_mid_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
